// File: rtl/memory_apb_pkg.sv
// Shared definitions for the APB3 register-memory slave: FSM encoding,
// wait-counter width and register-region decode helpers.
package memory_apb_pkg;

   localparam int CNT_BITS = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      REG_RW   = 2'd0,
      REG_RO   = 2'd1,
      REG_NONE = 2'd2
   } region_t;

   function automatic int unsigned rw_end(input int unsigned rw_size);
      return rw_size;
   endfunction

   function automatic int unsigned ro_end(input int unsigned rw_size,
                                          input int unsigned ro_size);
      return rw_size + ro_size;
   endfunction

   function automatic int cnt_bits();
      return CNT_BITS;
   endfunction

   // Indices are register numbers, so the region follows from two bounds.
   function automatic region_t region_of(input int unsigned idx,
                                         input int unsigned rw_size,
                                         input int unsigned ro_size);
      if (idx < rw_end(rw_size))
         return REG_RW;
      else if (idx < ro_end(rw_size, ro_size))
         return REG_RO;
      else
         return REG_NONE;
   endfunction

endpackage

// File: rtl/apb_wait_ctrl.sv
// APB3 transfer sequencer: IDLE -> (WAIT)* -> DONE with a programmable
// number of wait states, producing PREADY and the write-commit strobe.
module apb_wait_ctrl
   import memory_apb_pkg::*;
#(
   parameter int WAIT_STATES = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic psel,
   input  logic penable,
   output logic pready,
   output logic load,
   output logic enter_done,
   output logic commit
);

   logic [1:0]          state_q;
   logic [1:0]          state_d;
   logic [CNT_BITS-1:0] cnt_q;
   logic [CNT_BITS-1:0] cnt_d;

   // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d = ST_IDLE;
      cnt_d   = cnt_q;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (psel && !penable) begin
               load    = 1'b1;
               cnt_d   = CNT_BITS'(WAIT_STATES);
               state_d = (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Dropping PSEL mid-transfer abandons it without a commit.
            if (!psel) begin
               cnt_d = '0;
            end else begin
               cnt_d   = cnt_q - CNT_BITS'(1);
               state_d = (cnt_q == CNT_BITS'(1)) ? ST_DONE : ST_WAIT;
            end
         end
         ST_DONE: cnt_d = '0;
         default: cnt_d = '0;
      endcase
   end

   assign enter_done = (state_d == ST_DONE);
   assign commit     = (state_q == ST_DONE) && psel && penable;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pready  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pready  <= enter_done;
      end
   end

endmodule

// File: rtl/memory_apb3_slave.sv
// APB3 slave exposing RW_SIZE read/write registers followed by RO_SIZE
// read-only inputs, with wait states, PSLVERR and per-register write strobes.
module memory_apb3_slave
   import memory_apb_pkg::*;
#(
   parameter int                   ADDR_BITS      = 8,
   parameter int                   DATA_BITS      = 32,
   parameter int                   RW_SIZE        = 8,
   parameter int                   RO_SIZE        = 8,
   parameter int                   WAIT_STATES    = 0,
   parameter logic [DATA_BITS-1:0] RW_RESET_VALUE = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output logic [RW_SIZE*DATA_BITS-1:0] mem_rw_values,
   output logic [RW_SIZE-1:0]           mem_rw_written,
   input  logic [RO_SIZE*DATA_BITS-1:0] mem_ro_values,
   input  logic [ADDR_BITS-1:0]         PADDR,
   input  logic                         PSEL,
   input  logic                         PENABLE,
   input  logic                         PWRITE,
   input  logic [DATA_BITS-1:0]         PWDATA,
   output logic [DATA_BITS-1:0]         PRDATA,
   output logic                         PREADY,
   output logic                         PSLVERR
);

   logic load;
   logic enter_done;
   logic commit;

   apb_wait_ctrl #(
      .WAIT_STATES (WAIT_STATES)
   ) u_wait_ctrl (
      .clk        (clk),
      .rst_n      (rst_n),
      .psel       (PSEL),
      .penable    (PENABLE),
      .pready     (PREADY),
      .load       (load),
      .enter_done (enter_done),
      .commit     (commit)
   );

   logic [ADDR_BITS-1:0] addr_q;
   logic                 write_q;
   logic [DATA_BITS-1:0] wdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
      end else if (load) begin
         addr_q  <= PADDR;
         write_q <= PWRITE;
         wdata_q <= PWDATA;
      end
   end

   // With no wait states DONE is entered on the setup edge itself, before
   // the latched request exists, so the response decodes the live bus then.
   logic [ADDR_BITS-1:0] addr_eff;
   logic                 write_eff;
   logic [31:0]          eff_idx;
   logic [31:0]          q_idx;
   region_t              region_eff;
   region_t              region_q;

   assign addr_eff   = load ? PADDR : addr_q;
   assign write_eff  = load ? PWRITE : write_q;
   assign eff_idx    = 32'(addr_eff);
   assign q_idx      = 32'(addr_q);
   assign region_eff = region_of(eff_idx, RW_SIZE, RO_SIZE);
   assign region_q   = region_of(q_idx, RW_SIZE, RO_SIZE);

   logic [DATA_BITS-1:0] rw_regs [RW_SIZE];
   logic [DATA_BITS-1:0] rd_data;
   logic                 rd_err;

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < RW_SIZE; i++) begin
         if (eff_idx == 32'(i)) rd_data = rw_regs[i];
      end
      for (int i = 0; i < RO_SIZE; i++) begin
         if (eff_idx == 32'(RW_SIZE + i)) rd_data = mem_ro_values[i*DATA_BITS +: DATA_BITS];
      end
      if (write_eff) rd_data = '0;
   end

   assign rd_err = write_eff ? (region_eff != REG_RW) : (region_eff == REG_NONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         PRDATA  <= '0;
         PSLVERR <= 1'b0;
      end else if (enter_done) begin
         PRDATA  <= rd_data;
         PSLVERR <= rd_err;
      end
   end

   // NOTE: the register file drives mem_rw_values continuously, so it is built from flops and every entry is reset; a RAM could not be.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RW_SIZE; i++) rw_regs[i] <= RW_RESET_VALUE;
         mem_rw_written <= '0;
      end else begin
         mem_rw_written <= '0;
         if (commit && write_q && (region_q == REG_RW)) begin
            for (int i = 0; i < RW_SIZE; i++) begin
               if (q_idx == 32'(i)) begin
                  rw_regs[i]        <= wdata_q;
                  mem_rw_written[i] <= 1'b1;
               end
            end
         end
      end
   end

   for (genvar g = 0; g < RW_SIZE; g++) begin : g_rw_out
      assign mem_rw_values[g*DATA_BITS +: DATA_BITS] = rw_regs[g];
   end

endmodule

// File: tb/tb_memory_apb3_slave.sv
// Scoreboard bench: dut0 runs with two wait states, dut1 with none; the
// driver queues expected responses and a monitor checks completed transfers.
module tb_memory_apb3_slave;

   localparam logic [31:0] RST_VAL = 32'hA5A5_0000;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         psel    [2];
   logic         penable [2];
   logic         pwrite  [2];
   logic [7:0]   paddr   [2];
   logic [31:0]  pwdata  [2];
   logic [31:0]  prdata  [2];
   logic         pready  [2];
   logic         pslverr [2];
   logic [255:0] rw_vals [2];
   logic [7:0]   rw_written [2];
   logic [255:0] ro_vals [2];
   logic [255:0] model_rw [2];

   exp_t q0[$];
   exp_t q1[$];
   int   n_total = 0;
   int   n_pass  = 0;
   int   strobe_cnt [2] = '{0, 0};
   int   ready_cnt  [2] = '{0, 0};

   always #5 clk = ~clk;

   memory_apb3_slave #(
      .ADDR_BITS(8), .DATA_BITS(32), .RW_SIZE(8), .RO_SIZE(8),
      .WAIT_STATES(2), .RW_RESET_VALUE(RST_VAL)
   ) dut0 (
      .clk(clk), .rst_n(rst_n),
      .mem_rw_values(rw_vals[0]), .mem_rw_written(rw_written[0]), .mem_ro_values(ro_vals[0]),
      .PADDR(paddr[0]), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
      .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
   );

   memory_apb3_slave #(
      .ADDR_BITS(8), .DATA_BITS(32), .RW_SIZE(8), .RO_SIZE(8),
      .WAIT_STATES(0), .RW_RESET_VALUE(RST_VAL)
   ) dut1 (
      .clk(clk), .rst_n(rst_n),
      .mem_rw_values(rw_vals[1]), .mem_rw_written(rw_written[1]), .mem_ro_values(ro_vals[1]),
      .PADDR(paddr[1]), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
      .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
   );

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic sb_unexpected(input int d);
      n_total++;
      $display("FAIL dut%0d scoreboard: transfer completed with no expected entry", d);
   endtask

   // One APB transfer starting just after a rising edge; leaves the bus idle
   // so a following call issues its setup phase back-to-back.
   task automatic apb_xfer(input int d, input logic wr, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_data,
                           input logic exp_err, input int exp_wait);
      exp_t e;
      int   cycles;
      e.data = exp_data;
      e.err  = exp_err;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wdata;
      @(posedge clk); #1;
      penable[d] = 1'b1;
      cycles = 1;
      @(negedge clk);
      while (!pready[d] && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
      check($sformatf("dut%0d latency idx %0d", d, addr), 256'(cycles), 256'(exp_wait + 1));
      @(posedge clk); #1;
      psel[d] = 1'b0; penable[d] = 1'b0;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && psel[0] && penable[0] && pready[0]) begin
         if (q0.size() == 0) sb_unexpected(0);
         else begin
            e = q0.pop_front();
            check("dut0 PRDATA", 256'(prdata[0]), 256'(e.data));
            check("dut0 PSLVERR", 256'(pslverr[0]), 256'(e.err));
         end
      end
      if (rst_n && psel[1] && penable[1] && pready[1]) begin
         if (q1.size() == 0) sb_unexpected(1);
         else begin
            e = q1.pop_front();
            check("dut1 PRDATA", 256'(prdata[1]), 256'(e.data));
            check("dut1 PSLVERR", 256'(pslverr[1]), 256'(e.err));
         end
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rw_written[d] != 8'h00) strobe_cnt[d] <= strobe_cnt[d] + 1;
         if (pready[d])              ready_cnt[d]  <= ready_cnt[d] + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          s;
      int          r;
      logic [31:0] data;
      logic [31:0] exp_data;
      logic        exp_err;

      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
         model_rw[d] = {8{RST_VAL}};
         for (int i = 0; i < 8; i++) ro_vals[d][i*32 +: 32] = 32'hC0DE_0000 + 32'(i * 17 + d);
      end
      ro_vals[0][2*32 +: 32] = 32'h1234_5678;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset PREADY dut0", 256'(pready[0]), 256'(1'b0));
      check("reset PREADY dut1", 256'(pready[1]), 256'(1'b0));
      check("reset PRDATA", 256'(prdata[0]), 256'(32'h0));
      check("reset PSLVERR", 256'(pslverr[0]), 256'(1'b0));
      check("reset strobes", 256'(rw_written[0]), 256'(8'h00));
      check("reset rw values", rw_vals[0], model_rw[0]);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) apb_xfer(0, 1'b0, 8'(i), 32'h0, RST_VAL, 1'b0, 2);

      // Write with two wait states, strobe lasts one cycle
      apb_xfer(0, 1'b1, 8'd3, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
      model_rw[0][3*32 +: 32] = 32'hDEAD_BEEF;
      @(negedge clk);
      check("rw value idx3", 256'(rw_vals[0][127:96]), 256'(32'hDEAD_BEEF));
      check("strobe idx3", 256'(rw_written[0]), 256'(8'b0000_1000));
      @(negedge clk);
      check("strobe cleared", 256'(rw_written[0]), 256'(8'h00));
      @(posedge clk); #1;
      apb_xfer(0, 1'b0, 8'd3, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

      // Read-only region
      apb_xfer(0, 1'b0, 8'd10, 32'h0, 32'h1234_5678, 1'b0, 2);
      apb_xfer(0, 1'b1, 8'd10, 32'hFFFF_FFFF, 32'h0, 1'b1, 2);
      apb_xfer(0, 1'b0, 8'd10, 32'h0, 32'h1234_5678, 1'b0, 2);

      // Out-of-range accesses
      s = strobe_cnt[0];
      apb_xfer(0, 1'b0, 8'd16, 32'h0, 32'h0, 1'b1, 2);
      apb_xfer(0, 1'b0, 8'd255, 32'h0, 32'h0, 1'b1, 2);
      apb_xfer(0, 1'b1, 8'd20, 32'h5555_AAAA, 32'h0, 1'b1, 2);
      repeat (2) @(negedge clk);
      check("no strobe on error accesses", 256'(strobe_cnt[0]), 256'(s));
      check("rw values after error accesses", rw_vals[0], model_rw[0]);
      @(posedge clk); #1;

      // Abort: PSEL dropped in the first WAIT cycle
      apb_xfer(0, 1'b1, 8'd0, 32'h1111_2222, 32'h0, 1'b0, 2);
      model_rw[0][31:0] = 32'h1111_2222;
      s = strobe_cnt[0] + 1;
      r = ready_cnt[0];
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'd0; pwdata[0] = 32'h0000_00FF;
      @(posedge clk); #1;
      psel[0] = 1'b0;
      repeat (4) @(negedge clk);
      check("abort no strobe", 256'(strobe_cnt[0]), 256'(s));
      check("abort no PREADY", 256'(ready_cnt[0]), 256'(r));
      check("abort reg0 unchanged", 256'(rw_vals[0][31:0]), 256'(32'h1111_2222));
      @(posedge clk); #1;

      // Asynchronous reset in the middle of WAIT
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'd0; pwdata[0] = 32'h0000_00FF;
      @(posedge clk); #1;
      penable[0] = 1'b1;
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1;
      check("reset mid-WAIT PREADY", 256'(pready[0]), 256'(1'b0));
      check("reset mid-WAIT rw values", rw_vals[0], {8{RST_VAL}});
      psel[0] = 1'b0; penable[0] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_rw[0] = {8{RST_VAL}};
      model_rw[1] = {8{RST_VAL}};
      @(posedge clk); #1;
      apb_xfer(0, 1'b0, 8'd0, 32'h0, RST_VAL, 1'b0, 2);

      // Back-to-back traffic with no wait states
      for (int i = 0; i < 8; i++) begin
         data = $urandom;
         model_rw[1][i*32 +: 32] = data;
         apb_xfer(1, 1'b1, 8'(i), data, 32'h0, 1'b0, 0);
      end
      check("dut1 rw values after writes", rw_vals[1], model_rw[1]);
      for (int i = 0; i < 24; i++) begin
         if (i < 8) begin
            exp_data = model_rw[1][i*32 +: 32];
            exp_err  = 1'b0;
         end else if (i < 16) begin
            exp_data = ro_vals[1][(i-8)*32 +: 32];
            exp_err  = 1'b0;
         end else begin
            exp_data = 32'h0;
            exp_err  = 1'b1;
         end
         apb_xfer(1, 1'b0, 8'(i), 32'h0, exp_data, exp_err, 0);
      end

      repeat (2) @(negedge clk);
      check("scoreboard drained", 256'(q0.size() + q1.size()), 256'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
